// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: states, opcodes,
// ALU operation classes and datapath mux select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_LUI  = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_JAL       = 4'd10,
    S_BRANCH    = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [2:0] ALU_R     = 3'd0;
  localparam logic [2:0] ALU_I     = 3'd1;
  localparam logic [2:0] ALU_LUI   = 3'd2;
  localparam logic [2:0] ALU_STORE = 3'd3;
  localparam logic [2:0] ALU_LOAD  = 3'd4;
  localparam logic [2:0] ALU_JAL   = 3'd5;
  localparam logic [2:0] ALU_ADD   = 3'd6;
  localparam logic [2:0] ALU_SUB   = 3'd7;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;

  // States that own the shared memory port and therefore wait on mem_ready_i.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts not-ready cycles in a memory state; o_expired rises once the count
// equals MEM_TIMEOUT (never when MEM_TIMEOUT is 0).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMER_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TIMER_WIDTH-1:0] LP_LIMIT = TIMER_WIDTH'(MEM_TIMEOUT);

  logic [TIMER_WIDTH-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && (r_count == LP_LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RISC-V datapath.
// Optional BRANCH state enabled by defining MULTICYCLE_BRANCH_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 0,
  parameter int TIMER_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              OP_i,
  input  logic                    mem_ready_i,
  output logic                    pc_write_o,
  output logic                    ir_write_o,
  output logic                    i_or_d_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic                    reg_write_o,
  output logic                    mem_to_reg_o,
  output logic [1:0]              alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    pc_src_o,
  output logic                    branch_o,
  output logic                    illegal_o,
  output logic [3:0]              state_o
);

  state_e     r_state;
  state_e     w_next_state;
  logic       w_expired;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [2:0] w_alu_op;
`ifdef MULTICYCLE_BRANCH_EN
  logic       w_branch;
`endif

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_next_state != r_state),
    .i_inc     (is_mem_state(r_state) && !mem_ready_i),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_FETCH:     if (mem_ready_i) w_next_state = S_DECODE;
                   else if (w_expired) w_next_state = S_TRAP;
      S_DECODE: begin
        case (OP_i)
          OP_R:      w_next_state = S_EXEC_R;
          OP_I:      w_next_state = S_EXEC_I;
          OP_LUI:    w_next_state = S_EXEC_LUI;
          OP_LOAD,
          OP_STORE:  w_next_state = S_MEM_ADDR;
          OP_JAL:    w_next_state = S_JAL;
`ifdef MULTICYCLE_BRANCH_EN
          OP_BRANCH: w_next_state = S_BRANCH;
`endif
          default:   w_next_state = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: w_next_state = S_ALU_WB;
      S_MEM_ADDR:  w_next_state = (OP_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready_i) w_next_state = S_MEM_WB;
                   else if (w_expired) w_next_state = S_TRAP;
      S_MEM_WRITE: if (mem_ready_i) w_next_state = S_FETCH;
                   else if (w_expired) w_next_state = S_TRAP;
      S_ALU_WB, S_MEM_WB, S_JAL, S_BRANCH: w_next_state = S_FETCH;
      default:     w_next_state = S_TRAP;
    endcase
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_RS2;
    w_alu_op     = ALU_R;
    pc_src_o     = 1'b0;
`ifdef MULTICYCLE_BRANCH_EN
    w_branch     = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        w_alu_op    = ALU_ADD;
        w_ir_write  = mem_ready_i;
        w_pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        w_alu_op    = ALU_ADD;
      end
      S_EXEC_R: alu_src_a_o = SRC_A_RS1;
      S_EXEC_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        w_alu_op    = ALU_I;
      end
      S_EXEC_LUI: begin
        alu_src_b_o = SRC_B_IMM;
        w_alu_op    = ALU_LUI;
      end
      S_ALU_WB: w_reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        w_alu_op    = (OP_i == OP_STORE) ? ALU_STORE : ALU_LOAD;
      end
      S_MEM_READ: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        w_mem_write = 1'b1;
      end
      S_JAL: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        pc_src_o    = 1'b1;
        w_alu_op    = ALU_JAL;
      end
`ifdef MULTICYCLE_BRANCH_EN
      S_BRANCH: begin
        alu_src_a_o = SRC_A_RS1;
        w_alu_op    = ALU_SUB;
        w_branch    = 1'b1;
        pc_src_o    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Reset suppresses every write strobe so an interrupted instruction never
  // commits a partial writeback or PC update.
  assign pc_write_o  = w_pc_write  & ~reset;
  assign ir_write_o  = w_ir_write  & ~reset;
  assign mem_write_o = w_mem_write & ~reset;
  assign reg_write_o = w_reg_write & ~reset;

  assign alu_op_o  = ALU_OP_WIDTH'(w_alu_op);
  assign illegal_o = (r_state == S_TRAP);
  assign state_o   = r_state;
`ifdef MULTICYCLE_BRANCH_EN
  assign branch_o  = w_branch;
`else
  assign branch_o  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one DUT with MEM_TIMEOUT=5, a second
// with the timeout disabled, both driven by the same stimulus.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] OP_i = 7'h00;
  logic       mem_ready_i = 1'b0;

  logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       reg_write_o, mem_to_reg_o, pc_src_o, branch_o, illegal_o;
  logic [1:0] alu_src_a_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  logic       z_pc_write, z_ir_write, z_i_or_d, z_mem_read, z_mem_write;
  logic       z_reg_write, z_mem_to_reg, z_pc_src, z_branch, z_illegal;
  logic [1:0] z_src_a, z_src_b;
  logic [2:0] z_alu_op;
  logic [3:0] z_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_WIDTH(3), .MEM_TIMEOUT(5), .TIMER_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .branch_o(branch_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  multicycle_control #(.ALU_OP_WIDTH(3), .MEM_TIMEOUT(0), .TIMER_WIDTH(8)) dut_nt (
    .clk(clk), .reset(reset), .OP_i(OP_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(z_pc_write), .ir_write_o(z_ir_write), .i_or_d_o(z_i_or_d),
    .mem_read_o(z_mem_read), .mem_write_o(z_mem_write), .reg_write_o(z_reg_write),
    .mem_to_reg_o(z_mem_to_reg), .alu_src_a_o(z_src_a), .alu_src_b_o(z_src_b),
    .alu_op_o(z_alu_op), .pc_src_o(z_pc_src), .branch_o(z_branch),
    .illegal_o(z_illegal), .state_o(z_state)
  );

  // {pc_write, ir_write, mem_read, mem_write, reg_write}
  wire [4:0] strb = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic rdy);
    OP_i = op;
    mem_ready_i = rdy;
    #1;
  endtask

  task automatic check_cyc(input string tag, input state_e st, input logic [4:0] s);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".strb"}, 32'(strb), 32'(s));
  endtask

  // Holds reset for one edge (strobes must be gated while FETCH sees ready=1),
  // then releases it; the caller continues in cycle 1 of a FETCH.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive(7'h00, 1'b1);
    tick();
    #1;
    check_cyc({tag, ".rst"}, S_FETCH, 5'b00100);
    check({tag, ".rst_ill"}, 32'(illegal_o), 0);
    reset = 1'b0;
  endtask

  initial begin
    // R-type, zero wait states
    do_reset("r");
    drive(7'h33, 1'b1); check_cyc("r.c1", S_FETCH, 5'b11100);
    check("r.c1_aluop", 32'(alu_op_o), 6);
    check("r.c1_srcb", 32'(alu_src_b_o), 1);
    tick(); drive(7'h33, 1'b1); check_cyc("r.c2", S_DECODE, 5'b00000);
    check("r.c2_srca", 32'(alu_src_a_o), 2);
    check("r.c2_srcb", 32'(alu_src_b_o), 2);
    tick(); drive(7'h33, 1'b1); check_cyc("r.c3", S_EXEC_R, 5'b00000);
    check("r.c3_srca", 32'(alu_src_a_o), 1);
    check("r.c3_aluop", 32'(alu_op_o), 0);
    tick(); drive(7'h33, 1'b1); check_cyc("r.c4", S_ALU_WB, 5'b00001);
    check("r.c4_m2r", 32'(mem_to_reg_o), 0);
    tick(); drive(7'h33, 1'b1); check_cyc("r.c5", S_FETCH, 5'b11100);

    // I-type then LUI back to back
    tick(); drive(7'h13, 1'b1);
    tick(); drive(7'h13, 1'b1); check_cyc("i.c3", S_EXEC_I, 5'b00000);
    check("i.c3_aluop", 32'(alu_op_o), 1);
    check("i.c3_srcb", 32'(alu_src_b_o), 2);
    tick(); drive(7'h37, 1'b1); check_cyc("i.c4", S_ALU_WB, 5'b00001);
    tick(); drive(7'h37, 1'b1); check_cyc("lui.c1", S_FETCH, 5'b11100);
    tick(); drive(7'h37, 1'b1);
    tick(); drive(7'h37, 1'b1); check_cyc("lui.c3", S_EXEC_LUI, 5'b00000);
    check("lui.c3_aluop", 32'(alu_op_o), 2);
    tick(); drive(7'h37, 1'b1); check_cyc("lui.c4", S_ALU_WB, 5'b00001);

    // LW with 3 stall cycles; ready is low in DECODE/MEM_ADDR and must be ignored
    tick(); drive(7'h03, 1'b1); check_cyc("lw.c1", S_FETCH, 5'b11100);
    tick(); drive(7'h03, 1'b0); check_cyc("lw.c2", S_DECODE, 5'b00000);
    tick(); drive(7'h03, 1'b0); check_cyc("lw.c3", S_MEM_ADDR, 5'b00000);
    check("lw.c3_aluop", 32'(alu_op_o), 4);
    for (int c = 4; c <= 6; c++) begin
      tick(); drive(7'h03, 1'b0);
      check_cyc($sformatf("lw.c%0d", c), S_MEM_READ, 5'b00100);
      check($sformatf("lw.c%0d_iord", c), 32'(i_or_d_o), 1);
    end
    tick(); drive(7'h03, 1'b1); check_cyc("lw.c7", S_MEM_READ, 5'b00100);
    tick(); drive(7'h03, 1'b1); check_cyc("lw.c8", S_MEM_WB, 5'b00001);
    check("lw.c8_m2r", 32'(mem_to_reg_o), 1);

    // SW, zero wait states
    tick(); drive(7'h23, 1'b1); check_cyc("sw.c1", S_FETCH, 5'b11100);
    tick(); drive(7'h23, 1'b1);
    tick(); drive(7'h23, 1'b1); check_cyc("sw.c3", S_MEM_ADDR, 5'b00000);
    check("sw.c3_aluop", 32'(alu_op_o), 3);
    tick(); drive(7'h23, 1'b1); check_cyc("sw.c4", S_MEM_WRITE, 5'b00010);
    check("sw.c4_iord", 32'(i_or_d_o), 1);

    // JAL
    tick(); drive(7'h6F, 1'b1); check_cyc("jal.c1", S_FETCH, 5'b11100);
    tick(); drive(7'h6F, 1'b1);
    tick(); drive(7'h6F, 1'b1); check_cyc("jal.c3", S_JAL, 5'b10001);
    check("jal.c3_pcsrc", 32'(pc_src_o), 1);
    check("jal.c3_aluop", 32'(alu_op_o), 5);
    tick(); drive(7'h6F, 1'b1); check_cyc("jal.c4", S_FETCH, 5'b11100);

    // Ready arriving on the cycle the count hits MEM_TIMEOUT wins
    do_reset("tie");
    for (int c = 1; c <= 5; c++) begin
      drive(7'h33, 1'b0); tick();
    end
    drive(7'h33, 1'b1); check_cyc("tie.c6", S_FETCH, 5'b11100);
    tick(); drive(7'h33, 1'b1); check_cyc("tie.c7", S_DECODE, 5'b00000);

    // Timeout in FETCH: 5 wait cycles allowed, TRAP on the 6th not-ready cycle
    do_reset("to");
    for (int c = 1; c <= 6; c++) begin
      drive(7'h33, 1'b0);
      check($sformatf("to.c%0d_state", c), 32'(state_o), 32'(S_FETCH));
      tick();
    end
    drive(7'h33, 1'b1); check_cyc("to.c7", S_TRAP, 5'b00000);
    check("to.c7_ill", 32'(illegal_o), 1);
    check("to.c7_nt_state", 32'(z_state), 32'(S_FETCH));
    for (int c = 8; c <= 10; c++) begin
      tick(); drive(7'h33, 1'b1);
      check_cyc($sformatf("to.c%0d", c), S_TRAP, 5'b00000);
      check($sformatf("to.c%0d_ill", c), 32'(illegal_o), 1);
    end
    do_reset("to_exit");
    drive(7'h33, 1'b1); check("to.exit_ill", 32'(illegal_o), 0);

    // Illegal opcode traps straight out of DECODE with no strobes
    tick(); drive(7'h7F, 1'b1); check_cyc("ill.c2", S_DECODE, 5'b00000);
    for (int c = 3; c <= 5; c++) begin
      tick(); drive(7'h7F, 1'b1);
      check_cyc($sformatf("ill.c%0d", c), S_TRAP, 5'b00000);
      check($sformatf("ill.c%0d_ill", c), 32'(illegal_o), 1);
    end

    // Reset asserted during ALU_WB suppresses the writeback
    do_reset("mid");
    drive(7'h33, 1'b1);
    tick(); drive(7'h33, 1'b1);
    tick(); drive(7'h33, 1'b1);
    tick(); drive(7'h33, 1'b1); check_cyc("mid.c4", S_ALU_WB, 5'b00001);
    reset = 1'b1; #1;
    check("mid.c4_rw_rst", 32'(reg_write_o), 0);
    tick(); reset = 1'b0; drive(7'h33, 1'b1);
    check_cyc("mid.after", S_FETCH, 5'b11100);

    // Branch opcode
    tick(); drive(7'h63, 1'b1);
    tick(); drive(7'h63, 1'b1);
`ifdef MULTICYCLE_BRANCH_EN
    check_cyc("br.c3", S_BRANCH, 5'b00000);
    check("br.c3_branch", 32'(branch_o), 1);
    check("br.c3_aluop", 32'(alu_op_o), 7);
    check("br.c3_pcsrc", 32'(pc_src_o), 1);
    tick(); drive(7'h63, 1'b1); check_cyc("br.c4", S_FETCH, 5'b11100);
`else
    check_cyc("br.c3", S_TRAP, 5'b00000);
    check("br.c3_branch", 32'(branch_o), 0);
    check("br.c3_ill", 32'(illegal_o), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation RISC-V control unit for the multi-cycle datapath.
- Replaces per-opcode combinational decode with a Moore FSM that sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over one shared memory port.
- Stalls on a memory-ready handshake and flags illegal opcodes and memory timeouts.
- Sits between the instruction register and the datapath muxes, register-file and PC write enables.

Parameters:
- ALU_OP_WIDTH, 3: width of alu_op_o; must be >= 3.
- MEM_TIMEOUT, 0: maximum wait cycles for mem_ready_i in any memory state. 0 disables the timeout.
- TIMER_WIDTH, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TIMER_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OP_i  in  7  opcode field of the instruction register.
- mem_ready_i  in  1  memory completed the current read or write this cycle.
- pc_write_o  out  1  PC register write enable.
- ir_write_o  out  1  instruction register write enable.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- reg_write_o  out  1  register-file write enable.
- mem_to_reg_o  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- alu_src_a_o  out  2  ALU A select: 0 = PC, 1 = rs1, 2 = OldPC.
- alu_src_b_o  out  2  ALU B select: 0 = rs2, 1 = const 4, 2 = imm.
- alu_op_o  out  ALU_OP_WIDTH  ALU operation class.
- pc_src_o  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- branch_o  out  1  PC write conditional on the ALU zero flag.
- illegal_o  out  1  sticky fault flag.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. While reset=1, every write strobe is forced to 0. On the reset edge the state becomes FETCH, the wait counter is cleared and illegal_o is cleared to 0.
- Output decode: all outputs are decoded from the state register. Exceptions: pc_write_o and ir_write_o in FETCH are additionally qualified by mem_ready_i.
- FETCH outputs: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD(6). Stays in FETCH until mem_ready_i=1. On that cycle ir_write=1 and pc_write=1, then go to DECODE.
- DECODE outputs: alu_src_a=2, alu_src_b=2, alu_op=ADD, no strobes. Branch on OP_i:
  - 0x33 -> EXEC_R
  - 0x13 -> EXEC_I
  - 0x37 -> EXEC_LUI
  - 0x03 or 0x23 -> MEM_ADDR
  - 0x6F -> JAL
  - anything else -> TRAP
- EXEC_R: a=1, b=0, alu_op=0 -> ALU_WB.
- EXEC_I: a=1, b=2, alu_op=1 -> ALU_WB.
- EXEC_LUI: b=2, alu_op=2 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: a=1, b=2, alu_op=3 for SW or 4 for LW. Goes to MEM_WRITE (SW) or MEM_READ (LW).
- MEM_READ: i_or_d=1, mem_read=1. Holds until mem_ready_i, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WRITE: i_or_d=1, mem_write=1. Holds until mem_ready_i, then -> FETCH.
- JAL: reg_write=1 (rd = PC+4 from the datapath), pc_write=1, pc_src=1, alu_op=5 -> FETCH.
- TRAP: all strobes 0, illegal_o=1. Absorbing state; only reset exits.
- Latency with zero wait states:
  - R, I, LUI: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
  - JAL: 3 cycles
  - Each cycle of mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- Wait counter: cleared on entry to every memory state and incremented each cycle with mem_ready_i=0. If MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP.
- If mem_ready_i=1 arrives on the same cycle the count hits MEM_TIMEOUT, the ready wins.
- mem_ready_i is ignored outside memory states.
- Reset mid-instruction: no partial writeback or PC update happens on the reset cycle. The FSM restarts at FETCH.

Optional Feature:
- Macro: MULTICYCLE_BRANCH_EN.
- Defined: opcode 0x63 in DECODE goes to BRANCH. BRANCH outputs: a=1, b=0, alu_op=7 (SUB compare), branch_o=1, pc_src=1 -> FETCH (3 cycles).
- Undefined: 0x63 goes to TRAP and branch_o is tied to 0.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings
  - opcode constants
  - alu_op class codes 0..7
  - ALU A and B mux select codes
- One natural sub-module, mem_wait_timer: clear, increment, and expired flag compare against MEM_TIMEOUT.

Test Plan:
- R-type: OP_i=0x33, mem_ready_i always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write_o=1 only in cycle 4; pc_write_o=1 only in cycle 1.
- LW with stall: OP_i=0x03, mem_ready_i held 0 for 3 cycles in MEM_READ -> mem_read_o high for 4 cycles in MEM_READ; MEM_WB with mem_to_reg_o=1 at cycle 8.
- Timeout: MEM_TIMEOUT=5, mem_ready_i=0 in FETCH -> TRAP after 5 cycles; illegal_o=1 holds until reset; reset returns to FETCH with illegal_o=0.
- Illegal opcode: OP_i=0x7F in DECODE -> TRAP next cycle; no write strobe is ever asserted.
- Reset mid-op: assert reset in ALU_WB -> reg_write_o=0 on that cycle; FETCH on the next cycle.
- Branch: OP_i=0x63 with MULTICYCLE_BRANCH_EN defined -> branch_o=1 in cycle 3, alu_op_o=7. Without the macro -> TRAP.
